msi_vec_sched: RTL and testbench

//  Interrupt-vector scheduler behind the TRGT-side MSI detector. Each detected
//  MSI write sets a pending bit indexed by its data payload. Pending vectors are

---
 rtl/msi_vec_sched.sv | 136 +++++++++++++
 tb/tb_msi_vec_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msi_vec_sched.sv
// msi_vec_sched: MSI pending-vector register with round-robin req/ack
// service, ack timeout, software clear and saturating statistics.
module msi_vec_sched #(
    parameter int NVEC    = 32,
    parameter int VW      = $clog2(NVEC),
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             core_clk,
    input  logic             core_rst_n,
    input  logic             msi_detected,
    input  logic [31:0]      msi_data,
    input  logic [NVEC-1:0]  msi_en,
    input  logic [NVEC-1:0]  msi_mask,
    input  logic [NVEC-1:0]  msi_clear,
    input  logic             int_ack,
    output logic             int_req,
    output logic [VW-1:0]    int_vec,
    output logic [NVEC-1:0]  pending,
    output logic             timeout_err,
    output logic             bad_vec,
    output logic [CNT_W-1:0] coalesce_cnt,
    output logic [CNT_W-1:0] served_cnt
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    state_t          state;
    logic [VW-1:0]   rr_ptr;
    logic [TW-1:0]   tcnt;
    logic [VW-1:0]   msi_vec;
    logic            msi_bad;
    logic            msi_ok;
    logic [NVEC-1:0] set_mask;
    logic [NVEC-1:0] ack_mask;
    logic [NVEC-1:0] eligible;
    logic            ack_hit;
    logic            withdraw;
    logic            tmo;
    logic [VW-1:0]   pick;
    logic            found;

    assign msi_vec  = msi_data[VW-1:0];
    assign msi_bad  = msi_data >= 32'(NVEC);
    assign msi_ok   = msi_detected & ~msi_bad;
    assign set_mask = msi_ok ? (NVEC'(1) << msi_vec) : '0;
    assign eligible = pending & msi_en & ~msi_mask;

    // Exit causes in REQ are made exclusive: ack > withdraw > timeout.
    assign ack_hit  = (state == REQ) & int_ack;
    assign withdraw = (state == REQ) & ~int_ack & msi_clear[int_vec];
    assign tmo      = (state == REQ) & ~int_ack & ~msi_clear[int_vec]
                    & (tcnt == TW'(TIMEOUT - 1));
    assign ack_mask = ack_hit ? (NVEC'(1) << int_vec) : '0;

    // First eligible index strictly after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            if (!found && eligible[VW'((int'(rr_ptr) + 1 + i) % NVEC)]) begin
                found = 1'b1;
                pick  = VW'((int'(rr_ptr) + 1 + i) % NVEC);
            end
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            pending      <= '0;
            bad_vec      <= 1'b0;
            coalesce_cnt <= '0;
        end else begin
            pending <= (pending & ~msi_clear & ~ack_mask) | set_mask;
            bad_vec <= msi_detected & msi_bad;
            if (msi_ok && pending[msi_vec] && coalesce_cnt != '1)
                coalesce_cnt <= coalesce_cnt + 1'b1;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state       <= IDLE;
            rr_ptr      <= VW'(NVEC - 1);
            tcnt        <= '0;
            int_req     <= 1'b0;
            int_vec     <= '0;
            timeout_err <= 1'b0;
            served_cnt  <= '0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        int_vec <= pick;
                        int_req <= 1'b1;
                        tcnt    <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 1'b1;
                    unique case (1'b1)
                        ack_hit: begin
                            rr_ptr  <= int_vec;
                            int_req <= 1'b0;
                            state   <= GAP;
                            if (served_cnt != '1)
                                served_cnt <= served_cnt + 1'b1;
                        end
                        withdraw: begin
                            int_req <= 1'b0;
                            state   <= GAP;
                        end
                        tmo: begin
                            rr_ptr      <= int_vec;
                            timeout_err <= 1'b1;
                            int_req     <= 1'b0;
                            state       <= GAP;
                        end
                        default: ;
                    endcase
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_vec_sched.sv
// tb_msi_vec_sched: directed vectors with hand-computed expectations
// for the MSI vector scheduler (NVEC=32, TIMEOUT=16).
module tb_msi_vec_sched;

    logic        core_clk = 1'b0;
    logic        core_rst_n;
    logic        msi_detected;
    logic [31:0] msi_data;
    logic [31:0] msi_en;
    logic [31:0] msi_mask;
    logic [31:0] msi_clear;
    logic        int_ack;
    logic        int_req;
    logic [4:0]  int_vec;
    logic [31:0] pending;
    logic        timeout_err;
    logic        bad_vec;
    logic [15:0] coalesce_cnt;
    logic [15:0] served_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    msi_vec_sched #(
        .NVEC(32), .VW(5), .TIMEOUT(16), .CNT_W(16)
    ) dut (
        .core_clk     (core_clk),
        .core_rst_n   (core_rst_n),
        .msi_detected (msi_detected),
        .msi_data     (msi_data),
        .msi_en       (msi_en),
        .msi_mask     (msi_mask),
        .msi_clear    (msi_clear),
        .int_ack      (int_ack),
        .int_req      (int_req),
        .int_vec      (int_vec),
        .pending      (pending),
        .timeout_err  (timeout_err),
        .bad_vec      (bad_vec),
        .coalesce_cnt (coalesce_cnt),
        .served_cnt   (served_cnt)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic do_reset();
        core_rst_n = 1'b0;
        step();
        step();
        core_rst_n = 1'b1;
    endtask

    task automatic msi(input logic [31:0] d);
        msi_detected = 1'b1;
        msi_data     = d;
        step();
        msi_detected = 1'b0;
        msi_data     = '0;
    endtask

    task automatic serve(input int v);
        int n = 0;
        while (!int_req && n < 20) begin
            step();
            n++;
        end
        check("serve_req", int_req, 1);
        check("serve_vec", int_vec, v);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        msi_detected = 1'b0;
        msi_data     = '0;
        msi_en       = '1;
        msi_mask     = '0;
        msi_clear    = '0;
        int_ack      = 1'b0;
        do_reset();

        check("rst_req", int_req, 0);
        check("rst_vec", int_vec, 0);
        check("rst_pend", pending, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_bad", bad_vec, 0);
        check("rst_coal", coalesce_cnt, 0);
        check("rst_srv", served_cnt, 0);

        // basic service of vector 5
        msi(5);
        check("t1_pend", pending, 32'h20);
        check("t1_req0", int_req, 0);
        step();
        check("t1_req", int_req, 1);
        check("t1_vec", int_vec, 5);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("t1_pend_clr", pending, 0);
        check("t1_req_drop", int_req, 0);
        check("t1_srv", served_cnt, 1);

        // round-robin from rr=31, back-to-back latency, wrap
        do_reset();
        msi_mask = '1;
        msi(3);
        msi(7);
        msi(1);
        check("t2_pend", pending, 32'h8a);
        check("t2_noreq", int_req, 0);
        msi_mask = '0;
        step();
        check("t2_req1", int_req, 1);
        check("t2_vec1", int_vec, 1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("t2_gap_m1", int_req, 0);
        step();
        check("t2_gap_m2", int_req, 0);
        step();
        check("t2_req_m3", int_req, 1);
        check("t2_vec_m3", int_vec, 3);
        serve(3);
        serve(7);
        msi(2);
        serve(2);
        check("t2_srv", served_cnt, 4);
        check("t2_pend_end", pending, 0);

        // masked vector held pending until unmasked
        msi_mask = 32'h10;
        msi(4);
        check("t3_pend", pending, 32'h10);
        step();
        step();
        check("t3_noreq", int_req, 0);
        msi_mask = '0;
        n = 0;
        while (!int_req && n < 2) begin
            step();
            n++;
        end
        check("t3_req", int_req, 1);
        check("t3_vec", int_vec, 4);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;

        // ack timeout and reissue
        msi(10);
        step();
        n = 0;
        while (int_req && n < 40) begin
            n++;
            step();
        end
        check("t4_high_cycles", n, 16);
        check("t4_tmo", timeout_err, 1);
        check("t4_pend_kept", pending, 32'h400);
        check("t4_gap", int_req, 0);
        step();
        check("t4_tmo_pulse", timeout_err, 0);
        check("t4_idle", int_req, 0);
        step();
        check("t4_reissue", int_req, 1);
        check("t4_vec", int_vec, 10);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("t4_srv", served_cnt, 6);

        // coalescing and out-of-range vector
        msi(9);
        msi(9);
        check("t5_coal", coalesce_cnt, 1);
        check("t5_req", int_req, 1);
        check("t5_vec", int_vec, 9);
        msi(40);
        check("t5_bad", bad_vec, 1);
        check("t5_pend", pending, 32'h200);
        step();
        check("t5_bad_pulse", bad_vec, 0);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        check("t5_pend_clr", pending, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | int_req;
        end
        check("t5_single", seen, 0);
        check("t5_srv", served_cnt, 7);
        check("t5_coal_end", coalesce_cnt, 1);

        // software withdraw, then reset mid-request
        msi(6);
        step();
        check("t6_req", int_req, 1);
        check("t6_vec", int_vec, 6);
        msi_clear = 32'h40;
        step();
        msi_clear = '0;
        check("t6_wd_req", int_req, 0);
        check("t6_wd_pend", pending, 0);
        check("t6_wd_tmo", timeout_err, 0);
        check("t6_wd_srv", served_cnt, 7);
        msi(11);
        step();
        check("t6_req2", int_req, 1);
        core_rst_n = 1'b0;
        #1;
        check("t6_rst_req", int_req, 0);
        check("t6_rst_pend", pending, 0);
        check("t6_rst_vec", int_vec, 0);
        check("t6_rst_srv", served_cnt, 0);
        check("t6_rst_coal", coalesce_cnt, 0);
        step();
        core_rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
